// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - dot-product sequencer feeding the multiply-accumulate processor
// Optional feature macro: FEEDER_TIMEOUT_EN (WAIT watchdog, ERR state, sticky err flag)
module mac_operand_feeder #(
    parameter int DW    = 8,
    parameter int OUT_W = 16,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [DW-1:0]    a_data,
    input  logic             a_empty,
    output logic             a_pop,
    input  logic [DW-1:0]    b_data,
    input  logic             b_empty,
    output logic             b_pop,
    output logic [DW-1:0]    proc_a,
    output logic [DW-1:0]    proc_b,
    output logic             proc_enable,
    output logic             proc_retro,
    input  logic             proc_done,
    input  logic [OUT_W-1:0] proc_out,
    output logic [OUT_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             err
);

`ifdef FEEDER_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_RESULT = 3'd4,
        S_ERR    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_RESULT = 3'd4
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [DW-1:0]      proc_a_q, proc_a_d;
    logic [DW-1:0]      proc_b_q, proc_b_d;
    logic               proc_retro_q, proc_retro_d;
    logic [OUT_W-1:0]   res_data_q, res_data_d;
    logic               pop_both;
    logic               last_elem;

`ifdef FEEDER_TIMEOUT_EN
    logic [3:0]         tmo_cnt_q, tmo_cnt_d;
    logic               err_q, err_d;
`endif

    // Both FIFOs must have data before a pair is taken; pops are always paired.
    assign pop_both  = (state_q == S_FETCH) && !a_empty && !b_empty;
    assign last_elem = (idx_q == (len_q - LEN_W'(1)));

    // State register and datapath flops, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            proc_a_q     <= '0;
            proc_b_q     <= '0;
            proc_retro_q <= 1'b0;
            res_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            proc_a_q     <= proc_a_d;
            proc_b_q     <= proc_b_d;
            proc_retro_q <= proc_retro_d;
            res_data_q   <= res_data_d;
        end
    end

`ifdef FEEDER_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
`endif

    // Next-state and next-datapath logic for the run sequencer.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        proc_a_d     = proc_a_q;
        proc_b_d     = proc_b_q;
        proc_retro_d = proc_retro_q;
        res_data_d   = res_data_q;
`ifdef FEEDER_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                // The index is only ever cleared here, so it cannot wrap mid-run.
                idx_d = '0;
                if (start) begin
                    if (len != '0) begin
                        len_d   = len;
                        state_d = S_FETCH;
                    end else begin
                        res_data_d = '0;
                        state_d    = S_RESULT;
                    end
                end
            end
            S_FETCH: begin
                if (pop_both) begin
                    proc_a_d     = a_data;
                    proc_b_d     = b_data;
                    // First element loads the accumulator, the rest add into it.
                    proc_retro_d = (idx_q != '0);
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef FEEDER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (proc_done) begin
                    if (last_elem) begin
                        res_data_d = proc_out;
                        state_d    = S_RESULT;
                    end else begin
                        idx_d   = idx_q + LEN_W'(1);
                        state_d = S_FETCH;
                    end
                end
`ifdef FEEDER_TIMEOUT_EN
                else if (tmo_cnt_q == 4'd14) begin
                    // Fifteenth WAIT cycle without a completion: give up on the run.
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 4'd1;
                end
`endif
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
`ifdef FEEDER_TIMEOUT_EN
            S_ERR: begin
                state_d = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign a_pop       = pop_both;
    assign b_pop       = pop_both;
    assign proc_a      = proc_a_q;
    assign proc_b      = proc_b_q;
    assign proc_enable = (state_q == S_ISSUE);
    assign proc_retro  = proc_retro_q;
    assign res_data    = res_data_q;
    assign res_valid   = (state_q == S_RESULT);
    assign busy        = (state_q != S_IDLE);
`ifdef FEEDER_TIMEOUT_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

endmodule
